// File: rtl/frame_line_scheduler.sv
// Frame sequencer: walks lines at base + n*stride, requests each line from the offset
// former and forwards its bursts as absolute DMA commands. Optional abort: FRAME_SCHED_ABORT_EN.
module frame_line_scheduler #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int LINE_CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    input  logic [ADDR_W-1:0]     stride_i,
    input  logic [ADDR_W-1:0]     line_size_i,
    input  logic [LINE_CNT_W-1:0] line_cnt_i,
`ifdef FRAME_SCHED_ABORT_EN
    input  logic                  abort_i,
    output logic                  aborted_o,
`endif
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  new_line_o,
    output logic [ADDR_W-1:0]     line_size_o,
    input  logic [ADDR_W-1:0]     f_offset_i,
    input  logic [7:0]            f_burst_len_i,
    input  logic                  f_valid_i,
    input  logic                  f_last_i,
    output logic                  f_ready_o,
    output logic [ADDR_W-1:0]     cmd_addr_o,
    output logic [7:0]            cmd_len_o,
    output logic                  cmd_last_o,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i
);

    // Valid/ready: a transfer happens on any rising edge where valid && ready; a held
    // valid keeps its payload stable until accepted, on both the former and command side.

    if ((DATA_W < 8) || ((DATA_W & (DATA_W - 1)) != 0)) begin : g_bad_data_w
        $error("frame_line_scheduler: DATA_W must be a power of two >= 8");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LINE_REQ = 2'd1,
        S_RUN      = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_line_base;
    logic [ADDR_W-1:0]     r_stride;
    logic [ADDR_W-1:0]     r_line_size;
    logic [LINE_CNT_W-1:0] r_remaining;
    logic [ADDR_W-1:0]     r_cmd_addr;
    logic [7:0]            r_cmd_len;
    logic                  r_cmd_last;
    logic                  r_cmd_valid;
    logic                  r_done;
    logic                  w_start_acc;
    logic                  w_f_ready;
    logic                  w_f_hs;
    logic                  w_exit;
    logic                  w_abort;
    logic                  w_last_line;

`ifdef FRAME_SCHED_ABORT_EN
    logic r_abort;
    logic r_aborted;

    assign w_abort   = r_abort || (abort_i && ((r_state == S_LINE_REQ) || (r_state == S_RUN)));
    assign aborted_o = r_aborted;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_abort   <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_exit && r_abort;
            if (w_start_acc) begin
                r_abort <= 1'b0;
            end else if (w_abort) begin
                r_abort <= 1'b1;
            end
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    // An aborted frame finishes its current line and then treats it as the final one.
    assign w_last_line = (r_remaining == '0) || w_abort;

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_f_ready   = 1'b0;
        w_f_hs      = 1'b0;
        w_exit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The done cycle is still part of the previous frame, so start waits.
                if (start_i && !r_done) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_LINE_REQ;
                end
            end
            S_LINE_REQ: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_f_ready = !r_cmd_valid || cmd_ready_i;
                w_f_hs    = f_valid_i && w_f_ready;
                if (w_f_hs && f_last_i) begin
                    w_state_nxt = w_last_line ? S_DRAIN : S_LINE_REQ;
                end
            end
            S_DRAIN: begin
                if (!r_cmd_valid || cmd_ready_i) begin
                    w_exit      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_line_base <= '0;
            r_stride    <= '0;
            r_line_size <= '0;
            r_remaining <= '0;
            r_cmd_addr  <= '0;
            r_cmd_len   <= '0;
            r_cmd_last  <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_exit;
            if (w_start_acc) begin
                r_line_base <= base_addr_i;
                r_stride    <= stride_i;
                r_line_size <= line_size_i;
                r_remaining <= line_cnt_i;
            end else if (w_f_hs && f_last_i && !w_last_line) begin
                r_line_base <= r_line_base + r_stride;
                r_remaining <= r_remaining - LINE_CNT_W'(1);
            end
            // A new load wins over a simultaneous accept of the previous command.
            if (w_f_hs) begin
                r_cmd_valid <= 1'b1;
                r_cmd_addr  <= r_line_base + f_offset_i;
                r_cmd_len   <= f_burst_len_i;
                r_cmd_last  <= f_last_i && w_last_line;
            end else if (cmd_ready_i) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end

    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = r_done;
    assign new_line_o  = (r_state == S_LINE_REQ);
    assign line_size_o = r_line_size;
    assign f_ready_o   = w_f_ready;
    assign cmd_addr_o  = r_cmd_addr;
    assign cmd_len_o   = r_cmd_len;
    assign cmd_last_o  = r_cmd_last;
    assign cmd_valid_o = r_cmd_valid;

endmodule

// File: tb/tb_frame_line_scheduler.sv
// Directed bench for frame_line_scheduler: drives the former side by hand and checks
// accepted commands, line requests and completion timing against hand-computed values.
module tb_frame_line_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [31:0] stride_i = '0;
    logic [31:0] line_size_i = '0;
    logic [15:0] line_cnt_i = '0;
    logic        busy_o, done_o, new_line_o;
    logic [31:0] line_size_o;
    logic [31:0] f_offset_i = '0;
    logic [7:0]  f_burst_len_i = '0;
    logic        f_valid_i = 1'b0;
    logic        f_last_i = 1'b0;
    logic        f_ready_o;
    logic [31:0] cmd_addr_o;
    logic [7:0]  cmd_len_o;
    logic        cmd_last_o, cmd_valid_o;
    logic        cmd_ready_i = 1'b1;
`ifdef FRAME_SCHED_ABORT_EN
    logic        abort_i = 1'b0;
    logic        aborted_o;
`endif

    frame_line_scheduler #(.ADDR_W(32), .DATA_W(64), .LINE_CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .stride_i(stride_i),
        .line_size_i(line_size_i), .line_cnt_i(line_cnt_i),
`ifdef FRAME_SCHED_ABORT_EN
        .abort_i(abort_i), .aborted_o(aborted_o),
`endif
        .busy_o(busy_o), .done_o(done_o), .new_line_o(new_line_o),
        .line_size_o(line_size_o),
        .f_offset_i(f_offset_i), .f_burst_len_i(f_burst_len_i),
        .f_valid_i(f_valid_i), .f_last_i(f_last_i), .f_ready_o(f_ready_o),
        .cmd_addr_o(cmd_addr_o), .cmd_len_o(cmd_len_o), .cmd_last_o(cmd_last_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: entries packed as {last, len, addr}
    int          n_checks = 0;
    int          n_fail = 0;
    logic [40:0] exp_q[$];
    logic [40:0] got_q[$];
    int          cyc = 0;
    int          acc_cyc = 0;
    int          done_cyc = 0;
    int          nl_cnt = 0;
    int          done_cnt = 0;
    int          aborted_cnt = 0;

    always @(negedge clk_i) begin
        cyc++;
        if (!rst_i) begin
            if (cmd_valid_o && cmd_ready_i) begin
                got_q.push_back({cmd_last_o, cmd_len_o, cmd_addr_o});
                acc_cyc = cyc;
            end
            if (new_line_o) nl_cnt++;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
`ifdef FRAME_SCHED_ABORT_EN
            if (aborted_o && done_o) aborted_cnt++;
`endif
        end
    end

    // Driver tasks (all entered and left at posedge + 1)
    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        nl_cnt = 0;
        done_cnt = 0;
        aborted_cnt = 0;
    endtask

    task automatic start_frame(input logic [31:0] base, input logic [31:0] stride,
                               input logic [31:0] lsize, input logic [15:0] lcnt);
        base_addr_i = base;
        stride_i    = stride;
        line_size_i = lsize;
        line_cnt_i  = lcnt;
        start_i     = 1'b1;
        @(posedge clk_i); #1;
        start_i     = 1'b0;
    endtask

    task automatic wait_new_line();
        int t = 0;
        @(negedge clk_i);
        while (!new_line_o && t < 40) begin
            @(negedge clk_i);
            t++;
        end
        n_checks++;
        if (!new_line_o) begin
            n_fail++;
            $display("FAIL new_line_wait: new_line_o=%0b after %0d cycles, required 1", new_line_o, t);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic former_burst(input logic [31:0] off, input logic [7:0] len, input logic last);
        int t = 0;
        f_offset_i    = off;
        f_burst_len_i = len;
        f_last_i      = last;
        f_valid_i     = 1'b1;
        @(negedge clk_i);
        while (!f_ready_o && t < 40) begin
            @(negedge clk_i);
            t++;
        end
        if (!f_ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL former_handshake: f_ready_o=0 for %0d cycles, required 1", t);
        end
        @(posedge clk_i); #1;
        f_valid_i = 1'b0;
        f_last_i  = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge clk_i);
        while (!done_o && t < 40) begin
            @(negedge clk_i);
            t++;
        end
        n_checks++;
        if (!done_o) begin
            n_fail++;
            $display("FAIL done_wait: done_o=0 after %0d cycles, required 1", t);
        end else if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_at_done: busy_o=%0b, required 0", busy_o);
        end
        @(posedge clk_i); #1;
    endtask

    // Tests
    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if ({busy_o, done_o, new_line_o, f_ready_o, cmd_valid_o, cmd_last_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/nl/fready/cvalid/clast=%b, required 000000",
                     {busy_o, done_o, new_line_o, f_ready_o, cmd_valid_o, cmd_last_o});
        end
        n_checks++;
        if ({cmd_addr_o, cmd_len_o, line_size_o} !== 72'b0) begin
            n_fail++;
            $display("FAIL reset_fields: addr=%h len=%h lsize=%h, required 0", cmd_addr_o, cmd_len_o, line_size_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_single_line();
        clear_sb();
        cmd_ready_i = 1'b1;
        start_frame(32'h1000, 32'h0, 32'd59, 16'd0);
        n_checks++;
        if (line_size_o !== 32'd59 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_cfg: line_size_o=%0d busy_o=%0b, required 59 1", line_size_o, busy_o);
        end
        wait_new_line();
        former_burst(32'd0,   8'd15, 1'b0);
        former_burst(32'd128, 8'd15, 1'b0);
        former_burst(32'd256, 8'd15, 1'b0);
        former_burst(32'd384, 8'd11, 1'b1);
        wait_done();
        exp_q.push_back({1'b0, 8'd15, 32'h1000});
        exp_q.push_back({1'b0, 8'd15, 32'h1080});
        exp_q.push_back({1'b0, 8'd15, 32'h1100});
        exp_q.push_back({1'b1, 8'd11, 32'h1180});
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL single_count: %0d commands, required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL single_cmd%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (nl_cnt != 1 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL single_pulses: new_line=%0d done=%0d, required 1 1", nl_cnt, done_cnt);
        end
        n_checks++;
        if (done_cyc != acc_cyc + 1) begin
            n_fail++;
            $display("FAIL single_done_timing: done at cycle %0d, required %0d", done_cyc, acc_cyc + 1);
        end
    endtask

    task automatic test_three_lines();
        clear_sb();
        start_frame(32'h1000, 32'h2000, 32'd19, 16'd2);
        for (int l = 0; l < 3; l++) begin
            wait_new_line();
            former_burst(32'h0,  8'd15, 1'b0);
            former_burst(32'h80, 8'd3,  1'b1);
        end
        wait_done();
        exp_q.push_back({1'b0, 8'd15, 32'h1000});
        exp_q.push_back({1'b0, 8'd3,  32'h1080});
        exp_q.push_back({1'b0, 8'd15, 32'h3000});
        exp_q.push_back({1'b0, 8'd3,  32'h3080});
        exp_q.push_back({1'b0, 8'd15, 32'h5000});
        exp_q.push_back({1'b1, 8'd3,  32'h5080});
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL three_count: %0d commands, required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL three_cmd%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (nl_cnt != 3 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL three_pulses: new_line=%0d done=%0d, required 3 1", nl_cnt, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        clear_sb();
        cmd_ready_i = 1'b1;
        start_frame(32'h4000, 32'h0, 32'd31, 16'd0);
        wait_new_line();
        former_burst(32'h00, 8'd7, 1'b0);
        former_burst(32'h40, 8'd6, 1'b0);
        cmd_ready_i   = 1'b0;
        f_offset_i    = 32'h80;
        f_burst_len_i = 8'd5;
        f_valid_i     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            n_checks++;
            if (f_ready_o !== 1'b0 || cmd_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_ready%0d: f_ready_o=%0b cmd_valid_o=%0b, required 0 1", c, f_ready_o, cmd_valid_o);
            end
            n_checks++;
            if ({cmd_last_o, cmd_len_o, cmd_addr_o} !== {1'b0, 8'd6, 32'h4040}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got %h, required %h", c,
                         {cmd_last_o, cmd_len_o, cmd_addr_o}, {1'b0, 8'd6, 32'h4040});
            end
        end
        @(posedge clk_i); #1;
        cmd_ready_i = 1'b1;
        former_burst(32'h80, 8'd5, 1'b0);
        former_burst(32'hC0, 8'd4, 1'b1);
        wait_done();
        exp_q.push_back({1'b0, 8'd7, 32'h4000});
        exp_q.push_back({1'b0, 8'd6, 32'h4040});
        exp_q.push_back({1'b0, 8'd5, 32'h4080});
        exp_q.push_back({1'b1, 8'd4, 32'h40C0});
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_count: %0d commands, required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bp_cmd%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_wrap();
        clear_sb();
        start_frame(32'hFFFF_FF80, 32'h0, 32'd15, 16'd0);
        wait_new_line();
        former_burst(32'd0,   8'd7, 1'b0);
        former_burst(32'd128, 8'd7, 1'b1);
        wait_done();
        exp_q.push_back({1'b0, 8'd7, 32'hFFFF_FF80});
        exp_q.push_back({1'b1, 8'd7, 32'h0000_0000});
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL wrap_count: %0d commands, required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL wrap_cmd%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int t = 0;
        clear_sb();
        start_frame(32'h2000, 32'h100, 32'd9, 16'd1);
        wait_new_line();
        start_frame(32'h9000, 32'h40, 32'd77, 16'd5);
        n_checks++;
        if (line_size_o !== 32'd9) begin
            n_fail++;
            $display("FAIL busy_start_lsize: line_size_o=%0d, required 9", line_size_o);
        end
        former_burst(32'h10, 8'd4, 1'b1);
        wait_new_line();
        former_burst(32'h10, 8'd4, 1'b1);
        // Hold start through DRAIN and the done cycle: neither may accept it.
        start_i = 1'b1;
        wait_done();
        start_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b0 || new_line_o !== 1'b0) begin
            n_fail++;
            $display("FAIL start_at_done: busy_o=%0b new_line_o=%0b, required 0 0", busy_o, new_line_o);
        end
        @(posedge clk_i); #1;
        exp_q.push_back({1'b0, 8'd4, 32'h2010});
        exp_q.push_back({1'b1, 8'd4, 32'h2110});
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL busy_count: %0d commands, required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL busy_cmd%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (nl_cnt != 2 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL busy_pulses: new_line=%0d done=%0d, required 2 1", nl_cnt, done_cnt);
        end
    endtask

    task automatic test_reset_mid_line();
        clear_sb();
        cmd_ready_i = 1'b0;
        start_frame(32'h7000, 32'h0, 32'd21, 16'd3);
        wait_new_line();
        former_burst(32'h40, 8'd9, 1'b0);
        f_offset_i = 32'h80;
        f_valid_i  = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if ({busy_o, done_o, new_line_o, f_ready_o, cmd_valid_o, cmd_last_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL midreset_flags: busy/done/nl/fready/cvalid/clast=%b, required 000000",
                     {busy_o, done_o, new_line_o, f_ready_o, cmd_valid_o, cmd_last_o});
        end
        n_checks++;
        if ({cmd_addr_o, cmd_len_o, line_size_o} !== 72'b0) begin
            n_fail++;
            $display("FAIL midreset_fields: addr=%h len=%h lsize=%h, required 0", cmd_addr_o, cmd_len_o, line_size_o);
        end
        f_valid_i   = 1'b0;
        cmd_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b0 || new_line_o !== 1'b0 || cmd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_idle: busy=%0b nl=%0b cvalid=%0b, required 0 0 0", busy_o, new_line_o, cmd_valid_o);
        end
        @(posedge clk_i); #1;
    endtask

`ifdef FRAME_SCHED_ABORT_EN
    task automatic test_abort();
        clear_sb();
        start_frame(32'h1000, 32'h1000, 32'd15, 16'd3);
        wait_new_line();
        former_burst(32'h0, 8'd15, 1'b1);
        wait_new_line();
        abort_i = 1'b1;
        former_burst(32'h0, 8'd15, 1'b0);
        abort_i = 1'b0;
        former_burst(32'h80, 8'd2, 1'b1);
        wait_done();
        repeat (3) @(negedge clk_i);
        @(posedge clk_i); #1;
        exp_q.push_back({1'b0, 8'd15, 32'h1000});
        exp_q.push_back({1'b0, 8'd15, 32'h2000});
        exp_q.push_back({1'b1, 8'd2,  32'h2080});
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL abort_count: %0d commands, required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL abort_cmd%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (nl_cnt != 2 || done_cnt != 1 || aborted_cnt != 1) begin
            n_fail++;
            $display("FAIL abort_pulses: new_line=%0d done=%0d aborted_with_done=%0d, required 2 1 1",
                     nl_cnt, done_cnt, aborted_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_line();
        test_three_lines();
        test_backpressure();
        test_wrap();
        test_start_while_busy();
        test_reset_mid_line();
`ifdef FRAME_SCHED_ABORT_EN
        test_abort();
`endif
        test_single_line();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
